// File: rtl/pi_spi_bridge.sv
// pi_spi_bridge
// SPI (mode 0) slave running in the system clock domain. Decodes the Pi's
// byte command protocol into single-cycle write/read strobes on the
// pi_addr/pi_data bus that feeds the keyboard matrix cache and other
// Pi-visible registers. Read data returns on MISO.

module pi_spi_bridge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] pi_addr,
    output logic [7:0]  pi_data,
    output logic        pi_write,
    output logic        pi_read,
    input  logic [7:0]  pi_rd_data,
    input  logic        pi_rd_valid,
    output logic        rd_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        WDATA,
        RD_WAIT,
        RDATA,
        DISCARD
    } state_t;

    localparam logic [7:0] OP_WRITE      = 8'h80;
    localparam logic [7:0] OP_READ       = 8'hC0;
    localparam logic [7:0] OP_WRITE_NEXT = 8'h81;

    // Synchronizer chains and previous-value flops for edge detection
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_prev;
    logic                   cs_prev;

    // Synchronized pin values and detected events
    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_assert;
    logic cs_deassert;

    // Receive side
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic       byte_done;
    logic [7:0] rx_byte;

    // Protocol state
    state_t      state;
    logic        is_read;
    logic        first_wr;
    logic [7:0]  addr_hi_r;
    logic [7:0]  addr_lo_r;
    logic [7:0]  tx_shift;
    logic        wr_req;
    logic        rd_req;

    // Pin synchronizers; deliberately not reset so that a reset pulse in the
    // middle of a frame cannot fabricate a chip-select edge afterwards
    always_ff @(posedge clk) begin
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  spi_sck};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        sck_prev  <= sck_sync[SYNC_STAGES-1];
        cs_prev   <= cs_sync[SYNC_STAGES-1];
    end

    // Edge detection on the synchronized SCK and CS
    always_comb begin
        sck_s       = sck_sync[SYNC_STAGES-1];
        cs_s        = cs_sync[SYNC_STAGES-1];
        mosi_s      = mosi_sync[SYNC_STAGES-1];
        sck_rise    = sck_s & ~sck_prev;
        sck_fall    = ~sck_s & sck_prev;
        cs_assert   = ~cs_s & cs_prev;
        cs_deassert = cs_s & ~cs_prev;
    end

    // Bit counter and MOSI shift register; counter held clear while CS is high,
    // which also drops any partial byte left at the end of a frame
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else begin
            if (cs_s) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (sck_rise) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
            end
        end
    end

    // A byte completes on the 8th rise, including one coinciding with CS deassert
    always_comb begin
        byte_done = sck_rise && (bit_cnt == 3'd7);
        rx_byte   = {rx_shift, mosi_s};
    end

    // Command FSM: address/data update on the byte edge, strobe one clk later
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            is_read    <= 1'b0;
            first_wr   <= 1'b0;
            addr_hi_r  <= '0;
            addr_lo_r  <= '0;
            tx_shift   <= '0;
            wr_req     <= 1'b0;
            rd_req     <= 1'b0;
            pi_addr    <= '0;
            pi_data    <= '0;
            pi_write   <= 1'b0;
            pi_read    <= 1'b0;
            rd_timeout <= 1'b0;
        end else begin
            wr_req   <= 1'b0;
            rd_req   <= 1'b0;
            pi_write <= wr_req;
            pi_read  <= rd_req;

            // The fall right after the 8th rise (counter back at 0) must not
            // shift, so freshly loaded read data keeps its MSB on MISO
            if (sck_fall && (bit_cnt != 3'd0)) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            case (state)
                IDLE: begin
                    if (cs_assert) begin
                        state      <= CMD;
                        rd_timeout <= 1'b0;
                        tx_shift   <= '0;
                    end
                end

                CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            OP_WRITE: begin
                                is_read <= 1'b0;
                                state   <= ADDR_HI;
                            end
                            OP_READ: begin
                                is_read <= 1'b1;
                                state   <= ADDR_HI;
                            end
                            OP_WRITE_NEXT: begin
                                first_wr <= 1'b0;
                                state    <= WDATA;
                            end
                            default: state <= DISCARD;
                        endcase
                    end
                end

                ADDR_HI: begin
                    if (byte_done) begin
                        addr_hi_r <= rx_byte;
                        state     <= ADDR_LO;
                    end
                end

                ADDR_LO: begin
                    if (byte_done) begin
                        if (is_read) begin
                            pi_addr  <= {addr_hi_r, rx_byte};
                            rd_req   <= 1'b1;
                            tx_shift <= 8'hFF;
                            state    <= RD_WAIT;
                        end else begin
                            // pi_addr is only touched right before a strobe, so the
                            // write address waits here until the first data byte
                            addr_lo_r <= rx_byte;
                            first_wr  <= 1'b1;
                            state     <= WDATA;
                        end
                    end
                end

                WDATA: begin
                    if (byte_done) begin
                        pi_data  <= rx_byte;
                        wr_req   <= 1'b1;
                        first_wr <= 1'b0;
                        if (first_wr) begin
                            pi_addr <= {addr_hi_r, addr_lo_r};
                        end else begin
                            pi_addr <= pi_addr + 16'd1;
                        end
                    end
                end

                RD_WAIT: begin
                    // tx_shift was preloaded with 0xFF, so a host that clocks
                    // before the target answers reads all ones
                    if (sck_rise) begin
                        rd_timeout <= 1'b1;
                        state      <= RDATA;
                    end else if (pi_rd_valid) begin
                        tx_shift <= pi_rd_data;
                        state    <= RDATA;
                    end
                end

                RDATA: begin
                    if (byte_done) begin
                        pi_addr  <= pi_addr + 16'd1;
                        rd_req   <= 1'b1;
                        tx_shift <= 8'hFF;
                        state    <= RD_WAIT;
                    end
                end

                DISCARD: begin
                    tx_shift <= '0;
                end

                default: state <= IDLE;
            endcase

            // Placed last so a byte completing in the same cycle still strobes
            if (cs_deassert) begin
                state    <= IDLE;
                tx_shift <= '0;
            end
        end
    end

    assign spi_miso = tx_shift[7];

endmodule

// File: tb/tb_pi_spi_bridge.sv
// tb_pi_spi_bridge
// Directed SPI frames from a bit-banged host; expected strobes are queued as
// each frame is driven and checked when the bridge raises pi_write/pi_read.

module tb_pi_spi_bridge;

    localparam int  S    = 2;
    localparam time HALF = 50;
    localparam time GAP  = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] pi_addr;
    logic [7:0]  pi_data;
    logic        pi_write;
    logic        pi_read;
    logic [7:0]  pi_rd_data;
    logic        pi_rd_valid;
    logic        rd_timeout;

    always #5 clk = ~clk;

    pi_spi_bridge #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .pi_addr     (pi_addr),
        .pi_data     (pi_data),
        .pi_write    (pi_write),
        .pi_read     (pi_read),
        .pi_rd_data  (pi_rd_data),
        .pi_rd_valid (pi_rd_valid),
        .rd_timeout  (rd_timeout)
    );

    typedef struct packed {
        logic        is_rd;
        logic [15:0] addr;
        logic [7:0]  data;
    } strobe_t;

    strobe_t     sb[$];
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned rise8_cnt   = 0;
    bit          resp_en     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        strobe_t e;
        e.is_rd = 1'b0;
        e.addr  = a;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic expect_rd(input logic [15:0] a);
        strobe_t e;
        e.is_rd = 1'b1;
        e.addr  = a;
        e.data  = 8'h00;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] target_data(input logic [15:0] a);
        case (a)
            16'hE805: return 8'h5A;
            16'hE806: return 8'hA5;
            default:  return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    // One SPI byte, MSB first; MISO sampled on each rise
    task automatic xfer(input logic [7:0] b, input bit cs_on_last, output logic [7:0] r);
        logic [7:0] v;
        v = '0;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            #HALF;
            spi_sck = 1'b1;
            v[i] = spi_miso;
            if (i == 0) begin
                rise8_cnt++;
                if (cs_on_last) spi_cs_n = 1'b1;
            end
            #HALF;
            spi_sck = 1'b0;
        end
        r = v;
        #GAP;
    endtask

    task automatic partial(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            #HALF;
            spi_sck = 1'b1;
            #HALF;
            spi_sck = 1'b0;
        end
        #GAP;
    endtask

    task automatic run_frame();
        logic [7:0] r;
        rxq.delete();
        spi_cs_n = 1'b0;
        #GAP;
        foreach (txq[i]) begin
            xfer(txq[i], 1'b0, r);
            rxq.push_back(r);
        end
        spi_cs_n = 1'b1;
        #GAP;
    endtask

    // Target model: answers a read request on the following clock
    initial begin : responder
        pi_rd_valid = 1'b0;
        pi_rd_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            pi_rd_valid = 1'b0;
            if (pi_read === 1'b1 && resp_en) begin
                pi_rd_data  = target_data(pi_addr);
                pi_rd_valid = 1'b1;
            end
        end
    end

    // Strobe monitor: pops the scoreboard, checks latency, width and hold
    initial begin : monitor
        int unsigned since = 0;
        int unsigned seen  = 0;
        logic        pw    = 1'b0;
        logic        pr    = 1'b0;
        logic [15:0] pa    = '0;
        logic [7:0]  pd    = '0;
        strobe_t     e;
        forever begin
            @(posedge clk);
            if (rise8_cnt != seen) begin
                since = 0;
                seen  = rise8_cnt;
            end else begin
                since++;
            end
            #1;
            if (pi_write === 1'b1 || pi_read === 1'b1) begin
                check("strobe_exclusive", {31'b0, pi_write & pi_read}, 32'd0);
                check("strobe_latency", since, S + 1);
                check("addr_held", pi_addr, pa);
                if (pi_write === 1'b1) begin
                    check("write_width", {31'b0, pw}, 32'd0);
                    check("data_held", pi_data, pd);
                end else begin
                    check("read_width", {31'b0, pr}, 32'd0);
                end
                vectors++;
                assert (sb.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_strobe observed addr=%0h write=%0b expected none", pi_addr, pi_write);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("strobe_kind", {31'b0, pi_read}, {31'b0, e.is_rd});
                    check("strobe_addr", pi_addr, e.addr);
                    if (!e.is_rd) check("strobe_data", pi_data, e.data);
                end
            end
            pw = pi_write;
            pr = pi_read;
            pa = pi_addr;
            pd = pi_data;
        end
    end

    initial begin : stimulus
        logic [7:0] r;
        reset    = 1'b1;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values
        check("rst_addr", pi_addr, 16'h0000);
        check("rst_data", pi_data, 8'h00);
        check("rst_write", {31'b0, pi_write}, 32'd0);
        check("rst_read", {31'b0, pi_read}, 32'd0);
        check("rst_miso", {31'b0, spi_miso}, 32'd0);
        check("rst_timeout", {31'b0, rd_timeout}, 32'd0);

        // Single WRITE
        expect_wr(16'hE803, 8'h7F);
        txq = '{8'h80, 8'hE8, 8'h03, 8'h7F};
        run_frame();

        // Burst of ten, then WRITE_NEXT continues at the following address
        txq = '{8'h80, 8'hE8, 8'h00};
        for (int i = 0; i < 10; i++) begin
            txq.push_back(8'hFE - 8'(i));
            expect_wr(16'hE800 + 16'(i), 8'hFE - 8'(i));
        end
        run_frame();
        expect_wr(16'hE80A, 8'hAA);
        txq = '{8'h81, 8'hAA};
        run_frame();

        // READ with a responsive target; each completed dummy requests again
        resp_en = 1'b1;
        expect_rd(16'hE805);
        expect_rd(16'hE806);
        expect_rd(16'hE807);
        txq = '{8'hC0, 8'hE8, 8'h05, 8'h00, 8'h00};
        run_frame();
        check("rd_miso_cmd", rxq[0], 8'h00);
        check("rd_miso_b3", rxq[3], 8'h5A);
        check("rd_miso_b4", rxq[4], 8'hA5);
        check("rd_no_timeout", {31'b0, rd_timeout}, 32'd0);

        // READ with the target silent: dummy reads 0xFF and the flag sticks
        resp_en = 1'b0;
        expect_rd(16'h1234);
        expect_rd(16'h1235);
        spi_cs_n = 1'b0;
        #GAP;
        xfer(8'hC0, 1'b0, r);
        xfer(8'h12, 1'b0, r);
        xfer(8'h34, 1'b0, r);
        xfer(8'h00, 1'b0, r);
        check("to_miso", r, 8'hFF);
        check("to_flag_in_frame", {31'b0, rd_timeout}, 32'd1);
        spi_cs_n = 1'b1;
        #GAP;
        check("to_flag_after_cs", {31'b0, rd_timeout}, 32'd1);

        // Next CS assert clears the flag; partial data byte is dropped
        spi_cs_n = 1'b0;
        #GAP;
        check("to_flag_cleared", {31'b0, rd_timeout}, 32'd0);
        xfer(8'h81, 1'b0, r);
        partial(8'hC3, 5);
        spi_cs_n = 1'b1;
        #GAP;

        // Address wrap
        expect_wr(16'hFFFF, 8'h11);
        expect_wr(16'h0000, 8'h22);
        txq = '{8'h80, 8'hFF, 8'hFF, 8'h11, 8'h22};
        run_frame();

        // CS deassert coincident with the 8th rise still strobes
        expect_wr(16'h0001, 8'h3C);
        spi_cs_n = 1'b0;
        #GAP;
        xfer(8'h81, 1'b0, r);
        xfer(8'h3C, 1'b1, r);
        #GAP;

        // Unknown opcode: whole frame discarded
        txq = '{8'h55, 8'hAB, 8'hCD, 8'hEF};
        run_frame();
        check("discard_miso", rxq[2], 8'h00);

        // Reset in the middle of a frame
        spi_cs_n = 1'b0;
        #GAP;
        xfer(8'h80, 1'b0, r);
        xfer(8'hE8, 1'b0, r);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_addr", pi_addr, 16'h0000);
        check("mid_rst_data", pi_data, 8'h00);
        check("mid_rst_write", {31'b0, pi_write}, 32'd0);
        check("mid_rst_miso", {31'b0, spi_miso}, 32'd0);
        xfer(8'h03, 1'b0, r);
        xfer(8'h99, 1'b0, r);
        xfer(8'h77, 1'b0, r);
        spi_cs_n = 1'b1;
        #GAP;

        // Fresh frame after the aborted one
        expect_wr(16'hE807, 8'h42);
        txq = '{8'h80, 8'hE8, 8'h07, 8'h42};
        run_frame();

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pi_spi_bridge.md
# pi_spi_bridge

Deserializes SPI transactions from the Raspberry Pi into the parallel `pi_addr`/`pi_data`/`pi_write` bus that feeds the keyboard matrix cache ($E800-$E809) and other Pi-visible registers. It sits directly upstream of the keyboard block. It oversamples the asynchronous SPI pins in the system clock domain, decodes a byte-oriented command protocol, and issues single-cycle write and read strobes. Reads are returned on MISO.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on each SPI input pin. Minimum 2.

Ports:
- `clk`  in  1  system clock. Must be ≥ 8× SCK frequency.
- `reset`  in  1  synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `spi_sck`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0). Asynchronous to `clk`.
- `spi_cs_n`  in  1  chip select, active-low. Asynchronous.
- `spi_mosi`  in  1  serial data in, MSB first. Asynchronous.
- `spi_miso`  out  1  serial data out, MSB first. Low while `spi_cs_n` is high.
- `pi_addr`  out  16  target address. Held stable between strobes.
- `pi_data`  out  8  write data. Held stable between strobes.
- `pi_write`  out  1  one-`clk` write strobe.
- `pi_read`  out  1  one-`clk` read request.
- `pi_rd_data`  in  8  read data. Valid while `pi_rd_valid` is high.
- `pi_rd_valid`  in  1  read-data-valid strobe.
- `rd_timeout`  out  1  sticky error flag. Cleared by `reset` or by the next `spi_cs_n` falling edge.

## Operation
- Input conditioning:
  - Each SPI pin passes through `SYNC_STAGES` flops.
  - SCK rise and fall are detected from the synchronized SCK and its previous value.
  - CS assert and deassert are detected the same way.
- Bit handling:
  - MOSI is sampled on each detected SCK rise.
  - A 3-bit counter wraps 7→0. A byte is complete at the 8th rise.
  - MISO shifts on each detected SCK fall.
- Commands (first byte of a frame):
  - 0x80 WRITE: addr_hi, addr_lo, data0, data1, ...
  - 0xC0 READ: addr_hi, addr_lo, dummy0, dummy1, ...
  - 0x81 WRITE_NEXT: data0, data1, ..., using the current `pi_addr`.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, WDATA, RD_WAIT, RDATA, DISCARD.
  - IDLE→CMD on CS assert.
  - CMD→ADDR_HI on 0x80 or 0xC0.
  - CMD→WDATA on 0x81.
  - CMD→DISCARD on any other byte.
  - ADDR_HI→ADDR_LO.
  - ADDR_LO→WDATA for a write, with no increment before the first data byte.
  - ADDR_LO→RD_WAIT for a read; `pi_read` pulses with `pi_addr` loaded.
  - RD_WAIT→RDATA on `pi_rd_valid`. `pi_rd_data` loads the TX shift register and MSB drives MISO.
  - RDATA: at each completed dummy byte, `pi_addr` increments and `pi_read` pulses again, returning to RD_WAIT.
  - Any state→IDLE on CS deassert.
- WDATA: each completed byte loads `pi_data` and pulses `pi_write`. `pi_addr` increments after every data byte except the first of a WRITE frame.
  - Sequence is: strobe at A, then A+1, and so on.
  - Across WRITE_NEXT frames, the first byte goes to the last written address +1.
- Address arithmetic: 16-bit unsigned. 0xFFFF increments to 0x0000.
- Partial byte at CS deassert: discarded. No strobe. Bit counter cleared.
- DISCARD: ignores all bytes. No strobes. MISO held low.
- Read data missing: if an SCK rise occurs while in RD_WAIT, MISO shifts 0xFF for that byte and `rd_timeout` sets.
  - A late `pi_rd_valid` in that case is ignored; the FSM proceeds as though the byte completed.
- `pi_rd_valid` outside RD_WAIT is ignored.

## Timing
- Reset values:
  - `pi_addr`=0x0000, `pi_data`=0x00, `pi_write`=0, `pi_read`=0, `spi_miso`=0, `rd_timeout`=0.
  - FSM=IDLE, bit counter=0.
- Reset has priority over every SPI event. Reset mid-frame aborts the frame. The remainder of that frame is ignored until CS deasserts and reasserts.
- Strobe latency: `pi_write`/`pi_read` is high exactly one `clk`, `SYNC_STAGES`+1 cycles after the first `clk` edge that registers the 8th SCK rise.
- `pi_addr` and `pi_data` change only in the cycle before a strobe. They are held from at least 1 `clk` before the strobe until the next strobe.
  - This guarantees valid data at the negedge of `pi_write`.
- The host must leave ≥ (`SYNC_STAGES`+4) `clk` plus target read latency between the 8th SCK rise of addr_lo (or of a dummy byte) and the next SCK rise.
- A CS deassert detected in the same cycle as an 8th-bit SCK rise: the byte completes and strobes first, then the FSM goes to IDLE.
- Back-to-back strobes are separated by ≥ 8 SCK periods, hence ≥ 64 `clk`.

## Test plan
- WRITE: frame 80 E8 03 7F → one `pi_write` pulse with `pi_addr`=0xE803, `pi_data`=0x7F; no `pi_read`.
- Burst: frame 80 E8 00 FE FD … (10 data bytes) → 10 strobes, addresses 0xE800-0xE809 in order. Then frame 81 AA → strobe at 0xE80A with `pi_data`=0xAA.
- READ: frame C0 E8 05 00 00, target answering 0x5A then 0xA5 within 2 `clk` → MISO bytes 3 and 4 = 0x5A, 0xA5; `pi_read` at 0xE805 then 0xE806; `rd_timeout`=0.
- Read timeout: `pi_rd_valid` withheld → dummy byte returns 0xFF; `rd_timeout`=1 until the next CS assert.
- Abort and wrap:
  - CS deasserted after 5 bits of data → no strobe.
  - Frame 80 FF FF 11 22 → strobes at 0xFFFF and 0x0000.
  - Opcode 0x55 → no strobes for the whole frame.
- Reset mid-frame: `reset` pulse after addr_hi → all outputs at reset values; remaining bytes of that frame produce no strobe.
